// File: rtl/bytebeat_synth.sv
// Bytebeat audio generator: a divided sample counter t feeds one of eight
// integer formulas; the low byte of the chosen formula is registered as PCM.
module bytebeat_synth #(
  parameter int unsigned SAMPLE_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst_n,    // active-high asynchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0] div;
  logic [31:0] t;
  logic [7:0]  sample;
  logic [31:0] f;
  logic [2:0]  sel;
  logic [31:0] p_plus1;
  logic        unused_ok;

  assign sel     = ui_in[2:0];
  assign p_plus1 = {27'd0, ui_in[7:3]} + 32'd1;

  // uio_in is deliberately ignored
  assign unused_ok = ^uio_in;

  assign uo_out  = sample;
  assign uio_out = t[7:0];
  assign uio_oe  = 8'hFF;

  // Formula evaluation on the current (pre-edge) t; variable shifts >= 32 give 0
  always_comb begin
    f = '0;
    case (sel)
      3'd0: f = t;
      3'd1: f = t * (((t >> 12) | (t >> 8)) & 32'd63 & (t >> 4));
      3'd2: f = ((t * 32'd5) & (t >> 7)) | ((t * 32'd3) & (t >> 10));
      3'd3: f = t * ((t >> 5) | (t >> 8));
      3'd4: f = (((t >> 6) | t | (t >> (t >> 16))) * 32'd10) + ((t >> 11) & 32'd7);
      3'd5: f = t * (32'd42 & (t >> 10));
      3'd6: f = ((t * 32'd9) & (t >> 4)) | ((t * 32'd5) & (t >> 7))
              | ((t * 32'd3) & (t >> 10));
      3'd7: f = (t * p_plus1) & (t >> 8);
      default: f = '0;
    endcase
  end

  // Divider, sample counter and output register; all hold while ena is low
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div    <= '0;
      t      <= '0;
      sample <= '0;
    end else if (ena) begin
      if (div == DIV_LAST) begin
        div <= '0;
        t   <= t + 32'd1;
      end else begin
        div <= div + 16'd1;
      end
      sample <= f[7:0];
    end
  end

endmodule

// File: tb/tb_bytebeat_synth.sv
module tb_bytebeat_synth;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo4, uio4, oe4;
  logic [7:0] uo1, uio1, oe1;
  logic [31:0] preload_val;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bytebeat_synth #(.SAMPLE_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
  );

  bytebeat_synth #(.SAMPLE_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
  );

  typedef struct {
    logic [7:0] uo4;
    logic [7:0] uio4;
    logic [7:0] uo1;
    logic [7:0] uio1;
  } exp_t;

  exp_t q[$];

  // Reference model: n4 counts enabled clocks (t = n4/4 for the divide-by-4
  // instance); t1 is the sample counter of the divide-by-1 instance.
  longint unsigned n4;
  logic [31:0]     t1;
  logic [7:0]      s4, s1;

  function automatic longint unsigned shr(input longint unsigned x, input longint unsigned s);
    return (s >= 32) ? 64'd0 : (x >> s);
  endfunction

  function automatic logic [7:0] f_ref(input logic [2:0] sel, input logic [4:0] p,
                                       input longint unsigned t);
    longint unsigned r;
    longint unsigned pp;
    pp = longint'(p) + 1;
    case (sel)
      3'd0: r = t;
      3'd1: r = t * ((shr(t, 12) | shr(t, 8)) & 63 & shr(t, 4));
      3'd2: r = ((t * 5) & shr(t, 7)) | ((t * 3) & shr(t, 10));
      3'd3: r = t * (shr(t, 5) | shr(t, 8));
      3'd4: r = ((shr(t, 6) | t | shr(t, shr(t, 16))) * 10) + (shr(t, 11) & 7);
      3'd5: r = t * (42 & shr(t, 10));
      3'd6: r = ((t * 9) & shr(t, 4)) | ((t * 5) & shr(t, 7)) | ((t * 3) & shr(t, 10));
      default: r = (t * pp) & shr(t, 8);
    endcase
    r = r % 64'h1_0000_0000;
    return r[7:0];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Called at a negedge: apply inputs, predict the next edge, wait one cycle
  task automatic step(input logic en, input logic [7:0] ui);
    exp_t e;
    logic [31:0] tt;
    ena    = en;
    ui_in  = ui;
    uio_in = 8'($urandom);
    if (en) begin
      s4 = f_ref(ui[2:0], ui[7:3], n4 >> 2);
      s1 = f_ref(ui[2:0], ui[7:3], longint'(t1));
      n4 = n4 + 1;
      t1 = t1 + 32'd1;
    end
    tt     = 32'(n4 >> 2);
    e.uo4  = s4;
    e.uio4 = tt[7:0];
    e.uo1  = s1;
    e.uio1 = t1[7:0];
    q.push_back(e);
    @(negedge clk);
  endtask

  // Called at a negedge: reset lands between edges and must act immediately
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_uo4",  uo4,  8'h00);
    chk("rst_uio4", uio4, 8'h00);
    chk("rst_uo1",  uo1,  8'h00);
    chk("rst_uio1", uio1, 8'h00);
    ena = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_oe4", oe4, 8'hFF);
      chk("rst_oe1", oe1, 8'hFF);
      chk("rst_hold_uo1", uo1, 8'h00);
    end
    rst = 1'b0;
    n4 = 0;
    t1 = '0;
    s4 = '0;
    s1 = '0;
  endtask

  // Called at a negedge: overwrite the divide-by-1 counter between edges
  task automatic preload(input logic [31:0] v);
    preload_val = v;
    force u_div1.t = preload_val;
    #1 release u_div1.t;
    t1 = v;
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("uo_div4",  uo4,  e.uo4);
        chk("uio_div4", uio4, e.uio4);
        chk("uo_div1",  uo1,  e.uo1);
        chk("uio_div1", uio1, e.uio1);
      end
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = '0; uio_in = '0;
    n4 = 0; t1 = '0; s4 = '0; s1 = '0; preload_val = '0;
    @(negedge clk);
    do_reset();

    // Formula 0 counting for 40 clocks
    repeat (40) step(1'b1, 8'h00);
    chk("count40_uio4", uio4, 8'd10);

    // ena gating at t=5 of the divide-by-4 instance, mid divider phase
    do_reset();
    repeat (21) step(1'b1, 8'h00);
    repeat (20) step(1'b0, 8'h00);
    repeat (12) step(1'b1, 8'h00);

    // Directed formula points and a select switch at t=200
    do_reset();
    for (int unsigned i = 0; i < 260; i++) begin
      logic [7:0] ui;
      ui = 8'h00;
      if (t1 == 32'd33) ui = 8'h03;
      if (t1 >= 32'd200 && t1 < 32'd206) ui = 8'h03;
      if (t1 == 32'd256) ui = 8'h03;
      if (t1 == 32'd257) ui = 8'h07;
      step(1'b1, ui);
    end
    do_reset();
    repeat (256) step(1'b1, 8'h00);
    step(1'b1, 8'h0F);
    step(1'b1, 8'h07);

    // Wraparound of t
    preload(32'hFFFF_FFFE);
    repeat (3) step(1'b1, 8'h00);

    // Random selects, parameters and enables, at small and large t
    do_reset();
    repeat (400) step($urandom_range(0, 7) != 0, 8'($urandom));
    for (int unsigned k = 0; k < 6; k++) begin
      preload($urandom);
      repeat (150) step($urandom_range(0, 7) != 0, 8'($urandom));
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
